// File: rtl/alu_pkg.sv
// alu_pkg: opcodes, FSM state encoding and multiplier latency for alu_pipe
package alu_pkg;
  localparam logic [4:0] A_NOP  = 5'h00;
  localparam logic [4:0] A_ADD  = 5'h01;
  localparam logic [4:0] A_SUB  = 5'h02;
  localparam logic [4:0] A_AND  = 5'h03;
  localparam logic [4:0] A_OR   = 5'h04;
  localparam logic [4:0] A_XOR  = 5'h05;
  localparam logic [4:0] A_NOR  = 5'h06;
  localparam logic [4:0] A_SLT  = 5'h07;
  localparam logic [4:0] A_SLTU = 5'h08;
  localparam logic [4:0] A_SLL  = 5'h09;
  localparam logic [4:0] A_SRL  = 5'h0A;
  localparam logic [4:0] A_SRA  = 5'h0B;
  localparam logic [4:0] A_MUL  = 5'h0C;
  typedef enum logic {IDLE = 1'b0, MUL_BUSY = 1'b1} state_t;
  function automatic int mul_latency(input int width);
    return width;
  endfunction
endpackage

// File: rtl/alu_comb.sv
// alu_comb: combinational single-cycle ALU ops with carry/borrow and overflow
module alu_comb import alu_pkg::*; #(
  parameter int WIDTH = 32,
  parameter int OPW = 5
) (
  input  logic [OPW-1:0]   op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] res,
  output logic             c,
  output logic             v
);
  localparam int SW = $clog2(WIDTH);
  logic [WIDTH:0] sum;
  logic [WIDTH:0] dif;
  logic [SW-1:0]  sh;
  assign sum = {1'b0, a} + {1'b0, b};
  assign dif = {1'b0, a} - {1'b0, b};
  assign sh = b[SW-1:0];
  // result select; the extra sum bit gives carry, the extra difference bit gives borrow
  always_comb begin
    res = a;
    c = 1'b0;
    v = 1'b0;
    case (op)
      OPW'(A_ADD): begin
        res = sum[WIDTH-1:0];
        c = sum[WIDTH];
        v = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      OPW'(A_SUB): begin
        res = dif[WIDTH-1:0];
        c = dif[WIDTH];
        v = (a[WIDTH-1] != b[WIDTH-1]) && (dif[WIDTH-1] != a[WIDTH-1]);
      end
      OPW'(A_AND):  res = a & b;
      OPW'(A_OR):   res = a | b;
      OPW'(A_XOR):  res = a ^ b;
      OPW'(A_NOR):  res = ~(a | b);
      OPW'(A_SLT):  res = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
      OPW'(A_SLTU): res = {{(WIDTH-1){1'b0}}, a < b};
      OPW'(A_SLL):  res = a << sh;
      OPW'(A_SRL):  res = a >> sh;
      OPW'(A_SRA):  res = $signed(a) >>> sh;
      default:      res = a;
    endcase
  end
endmodule

// File: rtl/alu_pipe.sv
// alu_pipe: registered ALU with valid/ready handshakes and iterative shift-add multiplier
module alu_pipe import alu_pkg::*; #(
  parameter int WIDTH = 32,
  parameter int OPW = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] alu_a,
  input  logic [WIDTH-1:0] alu_b,
  input  logic [OPW-1:0]   alu_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] alu_out,
  output logic             flag_z,
  output logic             flag_n,
  output logic             flag_c,
  output logic             flag_v
);
  localparam int CW = $clog2(WIDTH);
  state_t state, state_nxt;
  logic [WIDTH-1:0] res;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] acc_nxt;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [CW-1:0]    cnt;
  logic             c;
  logic             v;
  logic             accept;
  logic             is_mul;
  logic             last;
  alu_comb #(.WIDTH(WIDTH), .OPW(OPW)) u_comb (
    .op(alu_op),
    .a(alu_a),
    .b(alu_b),
    .res(res),
    .c(c),
    .v(v)
  );
  assign in_ready = (state == IDLE) && (!out_valid || out_ready);
  assign accept = in_valid && in_ready;
  assign is_mul = alu_op == OPW'(A_MUL);
  assign last = cnt == CW'(mul_latency(WIDTH) - 1);
  assign acc_nxt = acc + (mplier[0] ? mcand : '0);
  // enter MUL_BUSY on a MUL accept, leave after the final iteration
  always_comb begin
    state_nxt = (state == IDLE && accept && is_mul) ? MUL_BUSY :
                (state == MUL_BUSY && last) ? IDLE : state;
  end
  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else state <= state_nxt;
  end
  // shift-add multiplier: one partial product per cycle while busy
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc <= '0;
      mcand <= '0;
      mplier <= '0;
      cnt <= '0;
    end else if (accept && is_mul) begin
      acc <= '0;
      mcand <= alu_a;
      mplier <= alu_b;
      cnt <= '0;
    end else if (state == MUL_BUSY) begin
      acc <= acc_nxt;
      mcand <= mcand << 1;
      mplier <= mplier >> 1;
      cnt <= cnt + 1'b1;
    end
  end
  // output slot: MUL completion, single-cycle result, or drain on transfer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      alu_out <= '0;
      flag_z <= 1'b0;
      flag_n <= 1'b0;
      flag_c <= 1'b0;
      flag_v <= 1'b0;
    end else if (state == MUL_BUSY && last) begin
      out_valid <= 1'b1;
      alu_out <= acc_nxt;
      flag_z <= acc_nxt == '0;
      flag_n <= acc_nxt[WIDTH-1];
      flag_c <= 1'b0;
      flag_v <= 1'b0;
    end else if (accept && !is_mul) begin
      out_valid <= 1'b1;
      alu_out <= res;
      flag_z <= res == '0;
      flag_n <= res[WIDTH-1];
      flag_c <= c;
      flag_v <= v;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: directed and randomized checks of alu_pipe against an arithmetic reference model
module tb_alu_pipe;
  localparam int W = 32;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0;
  logic out_ready = 1'b1;
  logic in_ready, out_valid, flag_z, flag_n, flag_c, flag_v;
  logic [W-1:0] alu_a = '0;
  logic [W-1:0] alu_b = '0;
  logic [W-1:0] alu_out;
  logic [4:0] alu_op = '0;
  int total = 0;
  int bad = 0;
  logic [W-1:0] edgev [4] = '{32'h0, 32'hFFFFFFFF, 32'h7FFFFFFF, 32'h80000000};

  always #5 clk = ~clk;

  alu_pipe #(.WIDTH(W), .OPW(5)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .out_valid(out_valid), .out_ready(out_ready), .alu_out(alu_out),
    .flag_z(flag_z), .flag_n(flag_n), .flag_c(flag_c), .flag_v(flag_v)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic [36:0] pk_dut();
    return {out_valid, flag_z, flag_n, flag_c, flag_v, alu_out};
  endfunction

  function automatic logic [36:0] ex(input logic [W-1:0] r, input logic c, input logic v);
    return {1'b1, r == '0, r[W-1], c, v, r};
  endfunction

  // reference: {c, v, result} from plain 64-bit arithmetic
  function automatic logic [W+1:0] model(input logic [4:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [63:0] ua = {32'h0, a};
    logic [63:0] ub = {32'h0, b};
    longint sa = longint'($signed(a));
    longint sb = longint'($signed(b));
    longint lim = longint'(1) << (W - 1);
    longint s;
    int amt = int'(b % W);
    logic [63:0] r = ua;
    logic c = 1'b0;
    logic v = 1'b0;
    case (op)
      5'h01: begin r = ua + ub; c = r[W]; s = sa + sb; v = (s >= lim) || (s < -lim); end
      5'h02: begin r = ua - ub; c = ua < ub; s = sa - sb; v = (s >= lim) || (s < -lim); end
      5'h03: r = ua & ub;
      5'h04: r = ua | ub;
      5'h05: r = ua ^ ub;
      5'h06: r = ~(ua | ub);
      5'h07: r = (sa < sb) ? 64'd1 : 64'd0;
      5'h08: r = (ua < ub) ? 64'd1 : 64'd0;
      5'h09: r = ua << amt;
      5'h0A: r = ua >> amt;
      5'h0B: begin
        r = ua >> amt;
        if (a[W-1]) r = r | ~(64'hFFFF_FFFF >> amt);
      end
      5'h0C: r = ua * ub;
      default: r = ua;
    endcase
    return {c, v, r[W-1:0]};
  endfunction

  task automatic send(input logic [4:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    int n = 0;
    alu_op = op;
    alu_a = a;
    alu_b = b;
    in_valid = 1'b1;
    while (!in_ready && n < 100) begin
      step(1);
      n++;
    end
    chk("accept_wait", n < 100, 1);
    step(1);
    in_valid = 1'b0;
  endtask

  task automatic op_chk(input string tag, input logic [4:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [36:0] exp);
    int n = 0;
    send(op, a, b);
    while (!out_valid && n < 100) begin
      step(1);
      n++;
    end
    chk(tag, pk_dut(), exp);
  endtask

  initial begin
    logic [W+1:0] m;
    logic [36:0] held;
    logic [4:0] op;
    logic [W-1:0] a, b;
    int k, ready_hi;
    step(2);
    chk("rst_outs", pk_dut(), 37'h0);
    rst = 1'b0;
    #1;
    chk("rst_ready", in_ready, 1);

    op_chk("add_ovf", 5'h01, 32'h7FFFFFFF, 32'h1, {1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 32'h80000000});
    op_chk("sub_zero", 5'h02, 32'd5, 32'd5, {1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0});
    op_chk("sub_borrow", 5'h02, 32'd3, 32'd5, {1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 32'hFFFFFFFE});
    op_chk("sra", 5'h0B, 32'h80000000, 32'h24, {1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'hF8000000});
    op_chk("srl", 5'h0A, 32'h80000000, 32'h24, {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h08000000});
    op_chk("slt", 5'h07, 32'hFFFFFFFF, 32'h1, {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h1});
    op_chk("sltu", 5'h08, 32'hFFFFFFFF, 32'h1, {1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0});
    op_chk("sll_zero_amt", 5'h09, 32'h12345678, 32'hFFFFFFE0, {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h12345678});
    op_chk("illegal_op", 5'h1F, 32'hCAFEF00D, 32'h1, {1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'hCAFEF00D});

    send(5'h0C, 32'hFFFFFFFD, 32'd7);
    alu_op = 5'h01;
    alu_a = 32'd1;
    alu_b = 32'd1;
    in_valid = 1'b1;
    k = 0;
    ready_hi = 0;
    while (!out_valid && k < 100) begin
      if (in_ready) ready_hi++;
      step(1);
      k++;
    end
    in_valid = 1'b0;
    chk("mul_latency", k, 32);
    chk("mul_ready_low", ready_hi, 0);
    chk("mul_result", pk_dut(), {1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'hFFFFFFEB});
    step(1);
    chk("mul_busy_ignored", out_valid, 0);

    out_ready = 1'b0;
    op_chk("bp_and", 5'h03, 32'hF0F0FF00, 32'h3C3C0FF0, {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h30300F00});
    held = pk_dut();
    step(3);
    chk("bp_held", pk_dut(), held);
    chk("bp_ready_low", in_ready, 0);
    out_ready = 1'b1;
    #1;
    chk("bp_ready_up", in_ready, 1);
    op_chk("bp_xor_nobubble", 5'h05, 32'hFFFF0000, 32'hFF00FF00, {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h00FFFF00});

    step(1);
    send(5'h0C, 32'd6, 32'd7);
    step(9);
    rst = 1'b1;
    #1;
    chk("rst_mid_mul", pk_dut(), 37'h0);
    step(1);
    rst = 1'b0;
    #1;
    op_chk("add_after_rst", 5'h01, 32'd2, 32'd2, {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd4});
    step(40);
    chk("no_stale_mul", out_valid, 0);

    for (int i = 0; i < 200; i++) begin
      op = 5'($urandom_range(0, 15));
      a = $urandom;
      b = $urandom;
      if ($urandom_range(0, 3) == 0) a = edgev[$urandom_range(0, 3)];
      if ($urandom_range(0, 3) == 0) b = edgev[$urandom_range(0, 3)];
      m = model(op, a, b);
      op_chk("random", op, a, b, ex(m[W-1:0], m[W+1], m[W]));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
